// File: rtl/sobel_frame_scheduler_if.sv
// Bundle of the scheduler's source, destination, engine and status signals.
// The master modport is the scheduler's view; slave is the environment's view.
interface sobel_frame_scheduler_if;
   logic        src0_req, src1_req;
   logic        src0_empty, src1_empty;
   logic [7:0]  src0_dout, src1_dout;
   logic        src0_rd_en, src1_rd_en;
   logic        dst0_full, dst1_full;
   logic        dst0_wr_en, dst1_wr_en;
   logic [7:0]  dst0_din, dst1_din;
   logic        eng_rd_en;
   logic        eng_empty;
   logic [7:0]  eng_dout;
   logic        eng_wr_en;
   logic [7:0]  eng_din;
   logic        eng_full;
   logic        eng_done;
   logic        eng_clr;
   logic        busy;
   logic [1:0]  grant;
   logic        frame_done;
   logic        frame_src;
   logic        err;
   logic [15:0] frame_cnt0, frame_cnt1;

   modport master (
      input  src0_req, src1_req, src0_empty, src1_empty, src0_dout, src1_dout,
             dst0_full, dst1_full, eng_rd_en, eng_wr_en, eng_din, eng_done,
      output src0_rd_en, src1_rd_en, dst0_wr_en, dst1_wr_en, dst0_din, dst1_din,
             eng_empty, eng_dout, eng_full, eng_clr, busy, grant, frame_done,
             frame_src, err, frame_cnt0, frame_cnt1
   );

   modport slave (
      output src0_req, src1_req, src0_empty, src1_empty, src0_dout, src1_dout,
             dst0_full, dst1_full, eng_rd_en, eng_wr_en, eng_din, eng_done,
      input  src0_rd_en, src1_rd_en, dst0_wr_en, dst1_wr_en, dst0_din, dst1_din,
             eng_empty, eng_dout, eng_full, eng_clr, busy, grant, frame_done,
             frame_src, err, frame_cnt0, frame_cnt1
   );
endinterface

// File: rtl/sobel_frame_scheduler.sv
// Shares one sobel engine between two grayscale sources, one whole frame at a time,
// clearing the engine first and draining unread source pixels after the engine finishes.
module sobel_frame_scheduler #(
   parameter int IMG_WIDTH  = 540,
   parameter int IMG_HEIGHT = 720,
   parameter int CLR_CYCLES = 2
) (
   input logic clock,
   input logic reset_n,
   sobel_frame_scheduler_if.master bus
);
   localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W     = $clog2(FRAME_PIX + 1);
   localparam int CLR_W     = $clog2(CLR_CYCLES + 1);
   localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(FRAME_PIX);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, FLUSH} state_t;

   state_t           state, state_nxt;
   logic [1:0]       grant_q;
   logic             last_src;
   logic [CNT_W-1:0] rd_cnt, wr_cnt, rd_nxt, wr_nxt;
   logic [CLR_W-1:0] clr_cnt;
   logic             wr_ovf;
   logic             eng_clr_q, frame_done_q, frame_src_q, err_q;
   logic [15:0]      frame_cnt0_q, frame_cnt1_q;

   logic             g, winner, complete, mismatch, drop_wr;
   logic             rd_sat, wr_sat, src_empty_g, dst_full_g;
   logic [7:0]       src_dout_g;
   logic             rd_en_g, wr_en_g, eng_empty_c, eng_full_c;
   logic [7:0]       eng_dout_c, dst_din_g;

   assign g           = grant_q[1];
   assign src_empty_g = g ? bus.src1_empty : bus.src0_empty;
   assign src_dout_g  = g ? bus.src1_dout  : bus.src0_dout;
   assign dst_full_g  = g ? bus.dst1_full  : bus.dst0_full;
   assign rd_sat      = (rd_cnt == PIX_MAX);
   assign wr_sat      = (wr_cnt == PIX_MAX);

   always_comb begin
      eng_empty_c = 1'b1;
      eng_full_c  = 1'b1;
      eng_dout_c  = 8'd0;
      dst_din_g   = 8'd0;
      rd_en_g     = 1'b0;
      wr_en_g     = 1'b0;
      drop_wr     = 1'b0;
      case (state)
         RUN: begin
            eng_dout_c  = src_dout_g;
            eng_empty_c = src_empty_g | rd_sat;
            eng_full_c  = dst_full_g;
            dst_din_g   = bus.eng_din;
            rd_en_g     = bus.eng_rd_en & ~(src_empty_g | rd_sat);
            wr_en_g     = bus.eng_wr_en & ~dst_full_g & ~wr_sat;
            drop_wr     = bus.eng_wr_en & ~dst_full_g & wr_sat;
         end
         FLUSH:   rd_en_g = ~src_empty_g & ~rd_sat;
         default: ;
      endcase
   end

   assign rd_nxt = rd_cnt + {{(CNT_W-1){1'b0}}, rd_en_g};
   assign wr_nxt = wr_cnt + {{(CNT_W-1){1'b0}}, wr_en_g};

   // Only a lone requester wins outright; a tie goes to the source not served last.
   assign winner = (bus.src0_req & bus.src1_req) ? ~last_src : bus.src1_req;

   // Writes dropped past a full frame also count as a mismatch, since the saturated
   // counter alone would hide them.
   assign mismatch = (state == RUN) & bus.eng_done & ((wr_nxt != PIX_MAX) | wr_ovf | drop_wr);

   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      case (state)
         IDLE:  if (bus.src0_req | bus.src1_req) state_nxt = CLEAR;
         CLEAR: if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = RUN;
         RUN: begin
            if (bus.eng_done) begin
               if (rd_nxt < PIX_MAX) begin
                  state_nxt = FLUSH;
               end else begin
                  state_nxt = IDLE;
                  complete  = 1'b1;
               end
            end
         end
         FLUSH: begin
            if (rd_nxt == PIX_MAX) begin
               state_nxt = IDLE;
               complete  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant_q      <= 2'b00;
         last_src     <= 1'b1;
         rd_cnt       <= '0;
         wr_cnt       <= '0;
         clr_cnt      <= '0;
         wr_ovf       <= 1'b0;
         eng_clr_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_src_q  <= 1'b0;
         err_q        <= 1'b0;
         frame_cnt0_q <= 16'd0;
         frame_cnt1_q <= 16'd0;
      end else begin
         eng_clr_q    <= (state_nxt == CLEAR);
         frame_done_q <= complete;
         rd_cnt       <= rd_nxt;
         wr_cnt       <= wr_nxt;
         if (drop_wr) wr_ovf <= 1'b1;
         if (state == CLEAR) clr_cnt <= clr_cnt + CLR_W'(1);
         if (mismatch) err_q <= 1'b1;
         if (state == IDLE && state_nxt == CLEAR) begin
            grant_q <= winner ? 2'b10 : 2'b01;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            clr_cnt <= '0;
            wr_ovf  <= 1'b0;
         end
         if (complete) begin
            grant_q     <= 2'b00;
            frame_src_q <= g;
            last_src    <= g;
            if (g) frame_cnt1_q <= frame_cnt1_q + 16'd1;
            else   frame_cnt0_q <= frame_cnt0_q + 16'd1;
         end
      end
   end

   assign bus.src0_rd_en = rd_en_g & ~g;
   assign bus.src1_rd_en = rd_en_g &  g;
   assign bus.dst0_wr_en = wr_en_g & ~g;
   assign bus.dst1_wr_en = wr_en_g &  g;
   assign bus.dst0_din   = g ? 8'd0 : dst_din_g;
   assign bus.dst1_din   = g ? dst_din_g : 8'd0;
   assign bus.eng_empty  = eng_empty_c;
   assign bus.eng_full   = eng_full_c;
   assign bus.eng_dout   = eng_dout_c;
   assign bus.eng_clr    = eng_clr_q;
   assign bus.busy       = (state != IDLE);
   assign bus.grant      = grant_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_src  = frame_src_q;
   assign bus.err        = err_q;
   assign bus.frame_cnt0 = frame_cnt0_q;
   assign bus.frame_cnt1 = frame_cnt1_q;
endmodule

// File: doc/sobel_frame_scheduler.md
# sobel_frame_scheduler

Frame-granular scheduler that shares one `sobel` edge engine between two grayscale sources and their two output FIFOs. It grants the engine to one source for exactly one frame and clears the engine before each frame. It routes the engine's FIFO handshakes to the granted source and destination, then flushes any unread source pixels after the engine reports done. It sits between the two grayscale FIFO pairs and the single `sobel` instance.

## Interface
- `IMG_WIDTH`, 540, pixels per line.
- `IMG_HEIGHT`, 720, lines per frame; `FRAME_PIX = IMG_WIDTH*IMG_HEIGHT`.
- `CLR_CYCLES`, 2, cycles `eng_clr` is held before each frame (≥1).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `src0_req`, `src1_req`  in  1 each  source has a frame queued (level).
- `src0_empty`, `src1_empty`  in  1 each  source FIFO empty.
- `src0_dout`, `src1_dout`  in  8 each  source FIFO data.
- `src0_rd_en`, `src1_rd_en`  out  1 each  source FIFO read.
- `dst0_full`, `dst1_full`  in  1 each  output FIFO full.
- `dst0_wr_en`, `dst1_wr_en`  out  1 each  output FIFO write.
- `dst0_din`, `dst1_din`  out  8 each  output FIFO data.
- `eng_rd_en`  in  1  engine `gray_rd_en`.
- `eng_empty`  out  1  engine `gray_empty`.
- `eng_dout`  out  8  engine `gray_dout`.
- `eng_wr_en`  in  1  engine `img_out_wr_en`.
- `eng_din`  in  8  engine `img_out_din`.
- `eng_full`  out  1  engine `img_out_full`.
- `eng_done`  in  1  engine `done` (one-cycle pulse).
- `eng_clr`  out  1  active-high clear to engine reset input, registered.
- `busy`  out  1  state ≠ IDLE.
- `grant`  out  2  one-hot active source; 00 in IDLE.
- `frame_done`  out  1  one-cycle pulse per completed frame.
- `frame_src`  out  1  source index of the last completed frame.
- `err`  out  1  sticky: write-count mismatch at `eng_done`.
- `frame_cnt0`, `frame_cnt1`  out  16 each  completed frames per source, wrapping.

## Operation
- FSM states: IDLE, CLEAR, RUN, FLUSH.
- IDLE:
  - If any `req` is high, pick the winner round-robin against `last_src`. `last_src` resets to 1, so src0 wins the first tie.
  - Register the winner into `grant`, clear `rd_cnt` and `wr_cnt`, then go to CLEAR.
  - Only one source requesting: that source wins regardless of `last_src`.
- CLEAR: `eng_clr`=1 for `CLR_CYCLES` cycles, then go to RUN with `eng_clr`=0.
- RUN, combinational pass-through for the granted source `g`:
  - `eng_dout`=`srcg_dout`.
  - `eng_empty` = `srcg_empty` OR (`rd_cnt`==`FRAME_PIX`).
  - `srcg_rd_en` = `eng_rd_en` AND NOT `eng_empty`.
  - `dstg_din`=`eng_din`, `eng_full`=`dstg_full`.
  - `dstg_wr_en` = `eng_wr_en` AND NOT `dstg_full` AND (`wr_cnt`<`FRAME_PIX`).
  - `rd_cnt`/`wr_cnt` increment on each accepted read/write and saturate at `FRAME_PIX`. Writes beyond `FRAME_PIX` are dropped.
- On `eng_done` in RUN:
  - If `wr_cnt`+(write accepted this cycle) ≠ `FRAME_PIX`, set `err`.
  - If `rd_cnt`<`FRAME_PIX`, go to FLUSH; else complete the frame.
- FLUSH:
  - `srcg_rd_en` = NOT `srcg_empty`; data is discarded; `eng_empty`=1, `eng_full`=1.
  - When `rd_cnt` reaches `FRAME_PIX`, complete the frame.
- Frame completion, in the cycle of entering IDLE:
  - Pulse `frame_done`; set `frame_src`=g.
  - Increment `frame_cntg`; set `last_src`=g.
  - Set `grant`=00.
- Non-granted source and destination: `rd_en`/`wr_en` held 0 at all times.
- Outside RUN: `eng_empty`=1, `eng_full`=1, `eng_dout`=0.
- `req` deassertion mid-frame is ignored; the grant holds until completion.

## Timing
- Reset values:
  - All `rd_en`/`wr_en` 0, `din` 0, `eng_clr` 0.
  - `eng_empty` 1, `eng_full` 1, `eng_dout` 0.
  - `busy` 0, `grant` 00, `frame_done` 0, `frame_src` 0, `err` 0.
  - `frame_cnt*` 0, `last_src` 1, state IDLE.
- Reset mid-frame: immediate return to reset values; counters cleared; no `frame_done`.
- `req` sampled in IDLE at edge N → `grant`/`eng_clr` high from N+1. RUN is entered at N+1+`CLR_CYCLES`.
- Data path in RUN has zero cycles of added latency; the engine sees the source FIFO as if directly attached.
- `eng_done` at edge M → `frame_done` at M+1 if no flush is needed. Otherwise `frame_done` comes in the cycle after the last flushed read.
- Earliest next grant is the cycle after `frame_done`, giving one IDLE cycle minimum between frames.
- `eng_done` outside RUN is ignored.

## Test plan
- **Single frame**, W=8, H=6, src0 only, engine model reads 48 and writes 48. Required: `grant`=01, `eng_clr` high exactly 2 cycles, 48 `dst0_wr_en`, 0 `dst1_wr_en`, `frame_done` one cycle after `eng_done`, `frame_cnt0`=1, `err`=0.
- **Simultaneous requests**, both `req` high continuously for 4 frames. Required: grant order src0, src1, src0, src1; `frame_cnt0`=`frame_cnt1`=2.
- **Flush**: engine reads 40 of 48 then pulses done. Required: FLUSH drains exactly 8 src pixels with no dst writes; `frame_done` after the 48th read.
- **Backpressure**: `dst1_full` toggled every other cycle during a src1 frame. Required: no write accepted while full; all 48 bytes arrive in order.
- **Mismatch**: engine writes 47 then pulses done. Required: `err`=1, sticky until reset. Separately, engine writes 50: `dst` receives 48 and `err`=1.
- **Reset mid-RUN** (`reset_n` low at pixel 20). Required: all outputs take their reset values asynchronously; a new frame afterwards completes normally with `frame_cnt`=1.
